bram_rmw_initiator: RTL and testbench
=====================================

Name: bram_rmw_initiator

Overview:
- Request-side controller that drives the 8192 x 64-bit on-chip BRAM port: en, addr, wdata, we_perbyte, with rdata returned one cycle after the access.
- Accepts single-beat read/write requests over a valid/ready interface and returns one response per request.
- The BRAM ignores individual byte-enable bits and writes the whole word, so this block performs read-modify-write for partial byte masks.
- Sits between the peripheral bus adapter and the boot/scratch BRAM.

Parameters:
ADDR_W, 13, BRAM word-address width
DATA_W, 64, word width in bits; STRB_W = DATA_W/8

Ports:
clock  in  1  system clock, all state updates on posedge
resetn  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_addr  in  ADDR_W  word address
req_write  in  1  1=write, 0=read
req_wdata  in  DATA_W  write data
req_wmask  in  STRB_W  byte-lane write mask, bit i covers wdata[8i+7:8i]
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_rdata  out  DATA_W  read data; 0 for writes
bram_en  out  1  BRAM enable
bram_addr  out  ADDR_W  BRAM address
bram_wdata  out  DATA_W  BRAM write data
bram_we_perbyte  out  STRB_W  BRAM write enables
bram_rdata  in  DATA_W  BRAM registered read data, valid the cycle after an en=1, we=0 access

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE, req_ready=0 while in reset, resp_valid=0, resp_rdata=0.
  - All bram_* outputs 0; latched request registers 0.
- State machine and BRAM outputs:
  - BRAM outputs are decoded from state and latched registers only.
  - In every state not listed below, bram_en=0 and bram_we_perbyte=0, with bram_addr and bram_wdata driven to 0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, latch addr, write, wdata and wmask.
  - Next state: read -> RD_ISSUE; write with mask=all-ones -> WR_ISSUE; write with mask=0 -> RESP (no BRAM access, resp_rdata=0); any other write -> RMW_RD.
- RD_ISSUE: bram_en=1, we_perbyte=0, addr=latched. Go to RD_CAP.
- RD_CAP: resp_rdata<=bram_rdata. Go to RESP.
- RMW_RD: bram_en=1, we_perbyte=0, addr=latched. Go to RMW_MERGE.
- RMW_MERGE:
  - merged byte i = wmask[i] ? wdata byte i : bram_rdata byte i; latched wdata<=merged.
  - Go to WR_ISSUE.
- WR_ISSUE:
  - bram_en=1, we_perbyte=all-ones (the BRAM collapses the mask to a single write enable), addr=latched, wdata=latched (merged).
  - resp_rdata<=0. Go to RESP.
- RESP: resp_valid=1 with resp_rdata held stable; on resp_ready, go to IDLE with resp_valid=0.
- req_ready=0 in every state except IDLE, so only one request is outstanding at a time and there is no pipelining.
- Latency from accept edge to first resp_valid cycle:
  - read: 3 cycles
  - full write: 2 cycles
  - partial write: 4 cycles
  - mask=0 write: 1 cycle
- Boundary behaviour:
  - Address wrap: none; all 2^ADDR_W addresses are valid and there is no bounds check.
  - resp_ready held high: RESP lasts exactly one cycle; the next request is accepted one cycle later, in IDLE.
  - resp_ready low: resp_valid and resp_rdata hold indefinitely; req_ready stays 0.
  - Reset mid-operation: immediate return to IDLE; a partial RMW write is dropped if reset is asserted before the WR_ISSUE edge; no response is issued for the aborted request.
  - Read of a location written by the immediately preceding request returns the new data, because the write has completed before the next RD_ISSUE.

Decomposition:
- Package bram_if_pkg:
  - ADDR_W and DATA_W defaults, and STRB_W.
  - State enum: IDLE, RD_ISSUE, RD_CAP, RMW_RD, RMW_MERGE, WR_ISSUE, RESP.
  - Constant MASK_FULL.
- Sub-module byte_merge: purely combinational per-lane mux of old data, new data and mask. It is instantiated once.

Test Plan:
- Preload word 5 = 0x0123456789ABCDEF; read addr 5 -> resp_valid 3 cycles after accept, resp_rdata=0x0123456789ABCDEF.
- Write addr 7, data 0xDEADBEEFCAFEF00D, mask 0xFF; then read addr 7 -> write response rdata=0; the read returns 0xDEADBEEFCAFEF00D; exactly one bram_en cycle is seen for the write.
- Word 9 = 0x1111111111111111; write addr 9, data 0xAAAAAAAAAAAAAAAA, mask 0x0F:
  - Bus shows one read cycle, then a write cycle with bram_wdata=0x11111111AAAAAAAA.
  - A following read of addr 9 returns 0x11111111AAAAAAAA.
- Write with mask 0x00 to addr 3 -> bram_en never asserts; resp_valid 1 cycle after accept; word 3 is unchanged.
- Read with resp_ready held low for 10 cycles -> resp_valid and resp_rdata stable throughout, req_ready=0; request accepted again in the cycle after resp_ready=1 leaves RESP.
- Assert resetn=0 during RMW_MERGE of a mask-0x01 write to addr 12 -> all outputs 0 immediately; word 12 is unchanged; no response; the next read works normally.

Source files
------------

// File: rtl/bram_if_pkg.sv
// Shared definitions for the BRAM read-modify-write initiator.
//   ADDR_W / DATA_W / STRB_W : default geometry of the 8192 x 64-bit BRAM
//   MASK_FULL                : byte mask that selects every lane of a DATA_W word
//   state_t                  : controller state encoding
package bram_if_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;
    localparam int STRB_W = DATA_W / 8;

    localparam logic [STRB_W-1:0] MASK_FULL = {STRB_W{1'b1}};

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RD_ISSUE  = 3'd1,
        RD_CAP    = 3'd2,
        RMW_RD    = 3'd3,
        RMW_MERGE = 3'd4,
        WR_ISSUE  = 3'd5,
        RESP      = 3'd6
    } state_t;

endpackage

// File: rtl/bram_rmw_initiator_byte_merge.sv
// byte_merge: combinational per-byte-lane merge of new write data over old data.
//   old_data : word read back from the BRAM
//   new_data : requested write data
//   mask     : lane i takes new_data when mask[i] is set, otherwise old_data
//   merged   : resulting word
module byte_merge #(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0]   old_data,
    input  logic [DATA_W-1:0]   new_data,
    input  logic [DATA_W/8-1:0] mask,
    output logic [DATA_W-1:0]   merged
);

    for (genvar g_lane = 0; g_lane < DATA_W / 8; g_lane++) begin : g_lanes
        assign merged[8*g_lane +: 8] = mask[g_lane] ? new_data[8*g_lane +: 8]
                                                    : old_data[8*g_lane +: 8];
    end

endmodule

// File: rtl/bram_rmw_initiator.sv
// bram_rmw_initiator: single-outstanding request controller for a word-wide BRAM
// that ignores byte enables. Partial-mask writes are turned into read-modify-write.
//   clock, resetn           : system clock, asynchronous active-low reset
//   req_*                   : valid/ready request (addr, write, wdata, wmask)
//   resp_*                  : valid/ready response carrying read data (0 for writes)
//   bram_en/addr/wdata/we   : BRAM port, decoded from state and latched request only
//   bram_rdata              : BRAM registered read data, valid one cycle after a read
//
// state     | meaning
// IDLE      | ready for a new request
// RD_ISSUE  | BRAM read of the requested word
// RD_CAP    | capture BRAM read data into the response register
// RMW_RD    | BRAM read of the word about to be partially overwritten
// RMW_MERGE | merge masked write bytes over the returned word
// WR_ISSUE  | full-word BRAM write of latched (possibly merged) data
// RESP      | response held until accepted
module bram_rmw_initiator
    import bram_if_pkg::*;
#(
    parameter int ADDR_W = bram_if_pkg::ADDR_W,
    parameter int DATA_W = bram_if_pkg::DATA_W
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_write,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wmask,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  bram_en,
    output logic [ADDR_W-1:0]     bram_addr,
    output logic [DATA_W-1:0]     bram_wdata,
    output logic [DATA_W/8-1:0]   bram_we_perbyte,
    input  logic [DATA_W-1:0]     bram_rdata
);

    localparam int LANES = DATA_W / 8;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_write;
    logic [DATA_W-1:0]   r_wdata;
    logic [LANES-1:0]    r_wmask;
    logic [DATA_W-1:0]   r_resp_rdata;
    logic [DATA_W-1:0]   w_merged;
    logic                w_accept;

    byte_merge #(.DATA_W(DATA_W)) u_byte_merge (
        .old_data (bram_rdata),
        .new_data (r_wdata),
        .mask     (r_wmask),
        .merged   (w_merged)
    );

    // resetn gates ready so nothing is offered while reset is held, even though
    // the state register already reads IDLE.
    assign req_ready  = (r_state == IDLE) && resetn;
    assign w_accept   = req_valid && req_ready;
    assign resp_valid = (r_state == RESP);
    assign resp_rdata = r_resp_rdata;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        bram_en         = 1'b0;
        bram_addr       = '0;
        bram_wdata      = '0;
        bram_we_perbyte = '0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (!req_write) begin
                        w_state_nxt = RD_ISSUE;
                    end else if (req_wmask == {LANES{1'b1}}) begin
                        w_state_nxt = WR_ISSUE;
                    end else if (req_wmask == '0) begin
                        w_state_nxt = RESP;
                    end else begin
                        w_state_nxt = RMW_RD;
                    end
                end
            end
            RD_ISSUE: begin
                bram_en     = 1'b1;
                bram_addr   = r_addr;
                w_state_nxt = RD_CAP;
            end
            RD_CAP: begin
                w_state_nxt = RESP;
            end
            RMW_RD: begin
                bram_en     = 1'b1;
                bram_addr   = r_addr;
                w_state_nxt = RMW_MERGE;
            end
            RMW_MERGE: begin
                w_state_nxt = WR_ISSUE;
            end
            WR_ISSUE: begin
                // The BRAM writes the whole word regardless, so all enables go high.
                bram_en         = 1'b1;
                bram_addr       = r_addr;
                bram_wdata      = r_wdata;
                bram_we_perbyte = {LANES{1'b1}};
                w_state_nxt     = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_resp_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr  <= req_addr;
                        r_write <= req_write;
                        r_wdata <= req_wdata;
                        r_wmask <= req_wmask;
                        // A mask-0 write goes straight to RESP and must report 0.
                        if (req_write) begin
                            r_resp_rdata <= '0;
                        end
                    end
                end
                RD_CAP: begin
                    r_resp_rdata <= r_write ? '0 : bram_rdata;
                end
                RMW_MERGE: begin
                    r_wdata <= w_merged;
                end
                WR_ISSUE: begin
                    r_resp_rdata <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bram_rmw_initiator.sv
module tb_bram_rmw_initiator;

    localparam int AW = 13;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic          clock;
    logic          resetn;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_write;
    logic [DW-1:0] req_wdata;
    logic [SW-1:0] req_wmask;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_rdata;
    logic          bram_en;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_wdata;
    logic [SW-1:0] bram_we_perbyte;
    logic [DW-1:0] bram_rdata;

    bram_rmw_initiator dut (
        .clock           (clock),
        .resetn          (resetn),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_addr        (req_addr),
        .req_write       (req_write),
        .req_wdata       (req_wdata),
        .req_wmask       (req_wmask),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .bram_en         (bram_en),
        .bram_addr       (bram_addr),
        .bram_wdata      (bram_wdata),
        .bram_we_perbyte (bram_we_perbyte),
        .bram_rdata      (bram_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // BRAM model: whole-word write whenever any enable is set; registered read.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          pl_we;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always @(posedge clock) begin
        if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end else if (bram_en) begin
            if (|bram_we_perbyte) mem[bram_addr] <= bram_wdata;
            else                  bram_rdata     <= mem[bram_addr];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clock);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clock);
        pl_we = 1'b0;
    endtask

    // Issues one request with resp_ready high and observes the BRAM port until
    // the response appears. lat counts cycles after the accept edge.
    task automatic do_req(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] m, output logic [DW-1:0] rd, output int lat,
                          output int ens, output int wens, output logic [DW-1:0] last_wd);
        int guard;
        rd = '0; lat = 0; ens = 0; wens = 0; last_wd = '0;
        @(negedge clock);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wmask = m;
        resp_ready = 1'b1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        @(posedge clock);
        #1 req_valid = 1'b0;
        while (lat < 20) begin
            @(negedge clock);
            lat++;
            if (bram_en) begin
                ens++;
                if (|bram_we_perbyte) begin
                    wens++;
                    last_wd = bram_wdata;
                end
            end
            if (resp_valid) begin
                rd = resp_rdata;
                break;
            end
        end
    endtask

    typedef struct {
        string         name;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wmask;
        logic [DW-1:0] exp_rd;
        int            exp_lat;
        int            exp_ens;
        int            exp_wens;
        logic [DW-1:0] exp_wd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [DW-1:0] rd, wd, held;
        int lat, ens, wens, guard;
        logic ok;

        vecs[0] = '{"rd5",      1'b0, 13'd5,    64'h0,                  8'h00, 64'h0123456789ABCDEF, 3, 1, 0, 64'h0};
        vecs[1] = '{"wr7full",  1'b1, 13'd7,    64'hDEADBEEFCAFEF00D,   8'hFF, 64'h0,                2, 1, 1, 64'hDEADBEEFCAFEF00D};
        vecs[2] = '{"rd7",      1'b0, 13'd7,    64'h0,                  8'h00, 64'hDEADBEEFCAFEF00D, 3, 1, 0, 64'h0};
        vecs[3] = '{"wr9part",  1'b1, 13'd9,    64'hAAAAAAAAAAAAAAAA,   8'h0F, 64'h0,                4, 2, 1, 64'h11111111AAAAAAAA};
        vecs[4] = '{"rd9",      1'b0, 13'd9,    64'h0,                  8'h00, 64'h11111111AAAAAAAA, 3, 1, 0, 64'h0};
        vecs[5] = '{"wr3mask0", 1'b1, 13'd3,    64'hFFFFFFFFFFFFFFFF,   8'h00, 64'h0,                1, 0, 0, 64'h0};
        vecs[6] = '{"rd3",      1'b0, 13'd3,    64'h0,                  8'h00, 64'h3333333333333333, 3, 1, 0, 64'h0};
        vecs[7] = '{"wrtoppart",1'b1, 13'd8191, 64'h0102030405060708,   8'h80, 64'h0,                4, 2, 1, 64'h01FFFFFFFFFFFFFF};
        vecs[8] = '{"rdtop",    1'b0, 13'd8191, 64'h0,                  8'h00, 64'h01FFFFFFFFFFFFFF, 3, 1, 0, 64'h0};
        vecs[9] = '{"rd0",      1'b0, 13'd0,    64'h0,                  8'h00, 64'hA5A5A5A5A5A5A5A5, 3, 1, 0, 64'h0};

        resetn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_wmask = '0; resp_ready = 1'b1;
        pl_we = 1'b0; pl_addr = '0; pl_data = '0;

        preload(13'd5,    64'h0123456789ABCDEF);
        preload(13'd9,    64'h1111111111111111);
        preload(13'd3,    64'h3333333333333333);
        preload(13'd8191, 64'hFFFFFFFFFFFFFFFF);
        preload(13'd0,    64'hA5A5A5A5A5A5A5A5);
        preload(13'd12,   64'h1212121212121212);

        @(negedge clock);
        check("rst_req_ready",  {63'd0, req_ready},  64'd0);
        check("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        check("rst_resp_rdata", resp_rdata,          64'd0);
        check("rst_bram", {bram_en, bram_we_perbyte, bram_addr, bram_wdata == '0}, {1'b0, 8'h00, 13'd0, 1'b1});
        resetn = 1'b1;
        @(negedge clock);
        check("idle_req_ready", {63'd0, req_ready}, 64'd1);

        for (int i = 0; i < 10; i++) begin
            do_req(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wmask, rd, lat, ens, wens, wd);
            check({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
            check({vecs[i].name, "_lat"},   64'(lat),  64'(vecs[i].exp_lat));
            check({vecs[i].name, "_en"},    64'(ens),  64'(vecs[i].exp_ens));
            check({vecs[i].name, "_wen"},   64'(wens), 64'(vecs[i].exp_wens));
            if (vecs[i].exp_wens != 0) check({vecs[i].name, "_wdata"}, wd, vecs[i].exp_wd);
        end
        check("mem3_unchanged", mem[3], 64'h3333333333333333);

        // Response back-pressure: hold resp_ready low for 10 cycles.
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 13'd5; req_wmask = '0;
        resp_ready = 1'b0;
        @(posedge clock);
        #1 req_valid = 1'b0;
        guard = 0;
        while (!resp_valid && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("stall_resp_seen", {63'd0, resp_valid}, 64'd1);
        held = resp_rdata;
        check("stall_rdata", held, 64'h0123456789ABCDEF);
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            ok = resp_valid && (resp_rdata == held) && !req_ready;
            check("stall_hold", {63'd0, ok}, 64'd1);
        end
        resp_ready = 1'b1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 13'd7;
        @(negedge clock);
        check("stall_release_valid", {63'd0, resp_valid}, 64'd0);
        check("stall_release_ready", {63'd0, req_ready},  64'd1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
        end
        check("after_stall_lat",   64'(lat), 64'd3);
        check("after_stall_rdata", resp_rdata, 64'hDEADBEEFCAFEF00D);

        // Reset during RMW_MERGE of a partial write to word 12.
        @(negedge clock);
        @(negedge clock);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 13'd12;
        req_wdata = 64'h00000000000000EE; req_wmask = 8'h01;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("rmw_rd_en", {63'd0, bram_en}, 64'd1);
        @(negedge clock);
        resetn = 1'b0;
        #1;
        check("abort_outputs", {bram_en, bram_we_perbyte, bram_addr, bram_wdata, req_ready, resp_valid, resp_rdata},
              {1'b0, 8'h00, 13'd0, 64'd0, 1'b0, 1'b0, 64'd0});
        ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (resp_valid || bram_en) ok = 1'b0;
        end
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (resp_valid || bram_en) ok = 1'b0;
        end
        check("abort_quiet", {63'd0, ok}, 64'd1);
        check("abort_mem12", mem[12], 64'h1212121212121212);
        do_req(1'b0, 13'd12, 64'h0, 8'h00, rd, lat, ens, wens, wd);
        check("post_abort_rdata", rd, 64'h1212121212121212);
        check("post_abort_lat",   64'(lat), 64'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
